// File: rtl/d_cache_dm.sv
// d_cache_dm: direct-mapped, write-back, write-allocate data cache.
//
// Sits between the core load/store port and a word-wide memory port. A miss
// stalls the core via d_miss_o while the line is filled; a dirty victim is
// written back first. flush_i writes back every dirty line. Requests outside
// the data segment, inside its null guard, or misaligned raise d_segfault_o.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   d_addr_i/d_rd_i/d_wr_i     core request (store wins over load)
//   d_wr_data_i                store data
//   d_miss_o                   combinational stall
//   d_rd_data_o, d_segfault_o  registered load data / fault flag
//   flush_i, flush_busy_o      flush command pulse / flush in progress
//   mem_req_o .. mem_wdata_o   registered memory beat request
//   mem_ack_i, mem_rdata_i     memory beat completion / read data
module d_cache_dm #(
  parameter int unsigned LINES    = 64,
  parameter int unsigned WORDS    = 4,
  parameter logic [31:0] SEG_BASE = 32'h0001_0000,
  parameter logic [31:0] SEG_SIZE = 32'h0000_1000,
  parameter logic [31:0] GUARD    = 32'h0000_0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_addr_i,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_wr_data_i,
  output logic        d_miss_o,
  output logic [31:0] d_rd_data_o,
  output logic        d_segfault_o,
  input  logic        flush_i,
  output logic        flush_busy_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned OffB  = $clog2(WORDS);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned TagSh = 2 + OffB + IdxW;
  localparam int unsigned TagW  = 32 - TagSh;
  localparam int unsigned BeatW = (WORDS > 1) ? OffB : 1;

  localparam logic [BeatW-1:0] LastBeat = BeatW'(WORDS - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(LINES - 1);
  localparam logic [31:0]      SegLo    = SEG_BASE + GUARD;
  localparam logic [31:0]      SegHi    = SEG_BASE + SEG_SIZE;

  typedef enum logic [2:0] {
    StIdle,
    StWb,
    StFill,
    StFlushScan,
    StFlushWb
  } state_e;

  // Storage: data and tags carry no reset; valid/dirty gate every use.
  logic [31:0]     data_arr [LINES][WORDS];
  logic [TagW-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid_q, dirty_q;

  state_e          state_q;
  logic [BeatW-1:0] beat_q;
  logic [IdxW-1:0] line_q;      // line under WB/FILL, or flush scan index
  logic [TagW-1:0] fill_tag_q;  // tag of the line being filled
  logic [31:0]     rd_data_q;
  logic            segfault_q, flush_busy_q;
  logic            mem_req_q, mem_we_q;
  logic [31:0]     mem_addr_q, mem_wdata_q;

  // Request decode
  logic [IdxW-1:0]  req_idx;
  logic [BeatW-1:0] req_off;
  logic [TagW-1:0]  req_tag;
  logic             req, fault, hit, victim_dirty, ack_ok, last_beat;
  logic             st_we, fill_we;

  assign req_idx = d_addr_i[2+OffB +: IdxW];
  assign req_off = (WORDS > 1) ? d_addr_i[2 +: BeatW] : '0;
  assign req_tag = d_addr_i[TagSh +: TagW];

  assign req          = d_rd_i | d_wr_i;
  assign fault        = (d_addr_i < SegLo) || (d_addr_i >= SegHi) || (d_addr_i[1:0] != 2'b00);
  assign hit          = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign ack_ok       = mem_req_q & mem_ack_i;
  assign last_beat    = (beat_q == LastBeat);

  assign st_we   = (state_q == StIdle) && req && !fault && hit && d_wr_i;
  assign fill_we = (state_q == StFill) && ack_ok;

  always_comb begin
    d_miss_o = 1'b0;
    if (state_q != StIdle) begin
      d_miss_o = 1'b1;
    end else if (req && !fault && !hit) begin
      d_miss_o = 1'b1;
    end
  end

  assign d_rd_data_o  = rd_data_q;
  assign d_segfault_o = segfault_q;
  assign flush_busy_o = flush_busy_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

  function automatic logic [31:0] mk_addr(input logic [TagW-1:0] t, input logic [IdxW-1:0] i,
                                          input logic [BeatW-1:0] b);
    logic [31:0] a;
    a = (32'(t) << TagSh) | (32'(i) << (2 + OffB));
    if (WORDS > 1) a = a | (32'(b) << 2);
    return a;
  endfunction

  // Array writes: store hits and fill beats never coincide (different states).
  always_ff @(posedge clk) begin
    if (st_we) data_arr[req_idx][req_off] <= d_wr_data_i;
    if (fill_we) begin
      data_arr[line_q][beat_q] <= mem_rdata_i;
      if (last_beat) tag_arr[line_q] <= fill_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      line_q       <= '0;
      fill_tag_q   <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      rd_data_q    <= '0;
      segfault_q   <= 1'b0;
      flush_busy_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rd_data_q    <= '0;
          segfault_q   <= 1'b0;
          flush_busy_q <= 1'b0;
          mem_req_q    <= 1'b0;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          if (req) begin
            if (fault) begin
              segfault_q <= 1'b1;
            end else if (hit) begin
              if (d_wr_i) dirty_q[req_idx] <= 1'b1;
              else        rd_data_q <= data_arr[req_idx][req_off];
            end else begin
              line_q     <= req_idx;
              fill_tag_q <= req_tag;
              beat_q     <= '0;
              mem_req_q  <= 1'b1;
              if (victim_dirty) begin
                state_q     <= StWb;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= mk_addr(tag_arr[req_idx], req_idx, '0);
                mem_wdata_q <= data_arr[req_idx][0];
              end else begin
                state_q          <= StFill;
                mem_addr_q       <= mk_addr(req_tag, req_idx, '0);
                valid_q[req_idx] <= 1'b0;
              end
            end
          end else if (flush_i) begin
            state_q      <= StFlushScan;
            line_q       <= '0;
            flush_busy_q <= 1'b1;
          end
        end

        StWb: begin
          if (ack_ok) begin
            if (last_beat) begin
              // Victim gone; reuse the line for the fill without dropping mem_req.
              state_q         <= StFill;
              beat_q          <= '0;
              valid_q[line_q] <= 1'b0;
              dirty_q[line_q] <= 1'b0;
              mem_we_q        <= 1'b0;
              mem_addr_q      <= mk_addr(fill_tag_q, line_q, '0);
              mem_wdata_q     <= '0;
            end else begin
              beat_q      <= beat_q + 1'b1;
              mem_addr_q  <= mk_addr(tag_arr[line_q], line_q, beat_q + 1'b1);
              mem_wdata_q <= data_arr[line_q][beat_q + 1'b1];
            end
          end
        end

        StFill: begin
          if (ack_ok) begin
            if (last_beat) begin
              state_q         <= StIdle;
              beat_q          <= '0;
              valid_q[line_q] <= 1'b1;
              dirty_q[line_q] <= 1'b0;
              mem_req_q       <= 1'b0;
              mem_addr_q      <= '0;
            end else begin
              beat_q     <= beat_q + 1'b1;
              mem_addr_q <= mk_addr(fill_tag_q, line_q, beat_q + 1'b1);
            end
          end
        end

        StFlushScan: begin
          if (valid_q[line_q] && dirty_q[line_q]) begin
            state_q     <= StFlushWb;
            beat_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mk_addr(tag_arr[line_q], line_q, '0);
            mem_wdata_q <= data_arr[line_q][0];
          end else if (line_q == LastIdx) begin
            state_q      <= StIdle;
            flush_busy_q <= 1'b0;
          end else begin
            line_q <= line_q + 1'b1;
          end
        end

        StFlushWb: begin
          if (ack_ok) begin
            if (last_beat) begin
              beat_q          <= '0;
              dirty_q[line_q] <= 1'b0;
              mem_req_q       <= 1'b0;
              mem_we_q        <= 1'b0;
              mem_addr_q      <= '0;
              mem_wdata_q     <= '0;
              if (line_q == LastIdx) begin
                state_q      <= StIdle;
                flush_busy_q <= 1'b0;
              end else begin
                state_q <= StFlushScan;
                line_q  <= line_q + 1'b1;
              end
            end else begin
              beat_q      <= beat_q + 1'b1;
              mem_addr_q  <= mk_addr(tag_arr[line_q], line_q, beat_q + 1'b1);
              mem_wdata_q <= data_arr[line_q][beat_q + 1'b1];
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/d_cache_dm.md
# d_cache_dm

Parametrised direct-mapped, write-back, write-allocate data cache sitting between the core's load/store port and an external word-wide memory port on the zedboard build. It keeps the single-cycle core interface with `d_miss` stall and `d_segfault` report. It adds the following behaviour:

- real tag/valid/dirty storage,
- line fill and victim writeback over a ready/ack handshake,
- a configurable data segment with alignment checking,
- an explicit flush command that writes back every dirty line.

## Interface
- `LINES`, 64: number of cache lines; power of 2, ≥2.
- `WORDS`, 4: 32-bit words per line; power of 2, ≥1.
- `SEG_BASE`, 32'h0001_0000: first byte address of the data segment.
- `SEG_SIZE`, 32'h0000_1000: segment size in bytes; power of 2.
- `GUARD`, 32'h0000_0200: low bytes of the segment that always fault (null guard).
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d_addr`  in  32  byte address; held stable by core while `d_miss`=1.
- `d_rd`  in  1  load request.
- `d_wr`  in  1  store request; wins if `d_rd` is also high.
- `d_wr_data`  in  32  store data.
- `d_miss`  out  1  combinational stall; core holds the request while high.
- `d_rd_data`  out  32  registered load data.
- `d_segfault`  out  1  registered fault flag.
- `flush`  in  1  one-cycle pulse: write back all dirty lines.
- `flush_busy`  out  1  high from the cycle after `flush` until flush completes.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  32  word-aligned beat address.
- `mem_wdata`  out  32  write-beat data.
- `mem_ack`  in  1  beat complete this cycle.
- `mem_rdata`  in  32  read data, valid when `mem_ack`=1 on a read beat.

## Operation

**Address split**
- `off` = `addr[2+log2(WORDS)-1:2]`.
- `idx` = next `log2(LINES)` bits.
- `tag` = remaining upper bits.
- Per line: `valid`, `dirty`, `tag`, and `WORDS` data words.
- Data array has no reset. `valid` and `dirty` are cleared on reset.

**Segfault**
- Applies to requests in IDLE only.
- Fault when `addr < SEG_BASE+GUARD`, or `addr >= SEG_BASE+SEG_SIZE`, or `addr[1:0] != 0`.
- A faulting request makes no array change and no memory access, and `d_miss`=0.

**FSM states: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB**
- **IDLE, no request:** all registered outputs go to 0.
- **IDLE, hit:**
  - Load: `d_rd_data` ← word.
  - Store: word ← `d_wr_data`, `dirty` ← 1, `d_rd_data` ← 0.
- **IDLE, miss:**
  - Victim valid and dirty → WB.
  - Otherwise → FILL.
- **WB:** `WORDS` write beats to `{victim_tag, idx, beat, 2'b00}`, beat 0 first. After the last ack → FILL.
- **FILL:**
  - `WORDS` read beats to `{tag, idx, beat, 2'b00}`, beat 0 first. Each acked word is written into the line.
  - After the last ack: `valid`←1, `dirty`←0, `tag` set, → IDLE.
  - The held request then hits.
- **FLUSH:**
  - `flush` in IDLE with no request → FLUSH_SCAN.
  - FLUSH_SCAN visits lines 0..`LINES`-1, one line per cycle.
  - A valid, dirty line → FLUSH_WB, which writes back all `WORDS` beats, clears `dirty`, and returns to the next index.
  - After the last line → IDLE. `flush` arriving with a request or outside IDLE is ignored.
- **`d_miss`:**
  - High when state ≠ IDLE.
  - High in IDLE when a non-faulting request misses.
  - High during flush.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- Reset asserted mid-WB/FILL/FLUSH: `mem_req` drops immediately, FSM returns to IDLE, all lines become invalid, and dirty data is lost.
- Hit latency: request in cycle N → `d_rd_data` valid in N+1. Stores complete at the N clock edge.
- Segfault: request in cycle N → `d_segfault`=1 in N+1. It stays 1 while the faulting request is held and clears in the cycle after the request drops.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered.
  - They are held constant until the cycle `mem_ack`=1, and advance to the next beat in the following cycle.
  - No beat is issued in the cycle `mem_ack` is seen for the final beat.
  - `mem_ack` with `mem_req`=0 is ignored.
- Clean miss: `WORDS` beats plus 1 cycle back to IDLE, then a hit.
- Dirty miss: 2×`WORDS` beats plus 1 cycle.
- Flush: `LINES` scan cycles plus `WORDS` beats per dirty line. `flush_busy` falls in the cycle FSM re-enters IDLE.
- Beat counter wraps to 0 at `WORDS`-1 and the flush index saturates at `LINES`-1. No overflow into tag/idx is allowed.

## Test plan
- **Cold load:** reset, load 0x0001_0204 with memory returning 0xA0+beat, ack 1 cycle after each req.
  - `d_miss`=1, 4 read beats at 0x0001_0200..020C.
  - Then `d_rd_data`=0xA1 one cycle after the hit.
- **Store/hit/evict:**
  - Store 0xDEAD_BEEF to 0x0001_0200 after it is filled → no memory beats.
  - Load 0x0001_0A00 (same idx, LINES=64, WORDS=4) → 4 write beats at 0x0001_0200.. with the first `mem_wdata`=0xDEAD_BEEF, then 4 read beats.
- **Segfaults:** addresses 0x0001_0100 (guard), 0x0001_1000 (limit) and 0x0001_0202 (misaligned).
  - Each gives `d_segfault`=1 next cycle, `d_miss`=0, `mem_req` never high.
  - Flag clears one cycle after the request drops.
- **Backpressure:** `mem_ack` delayed 5 cycles per beat. `mem_addr`/`mem_we` are stable across each wait and `d_miss` is held throughout.
- **Flush:** dirty lines 3 and 60, then `flush`.
  - Exactly 8 write beats, line 3 first.
  - `flush_busy` runs high until IDLE; a second flush issues 0 beats.
- **Reset mid-FILL:** assert `rst_n`=0 after beat 2.
  - `mem_req`=0 immediately.
  - The reload of the same address re-fills all 4 beats.
